// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter arbiter.
package uart_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int BUSY_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_START     = 2'd1,
    ARB_WAIT_BUSY = 2'd2,
    ARB_WAIT_DONE = 2'd3
  } uart_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: the first set request at or after last_grant+1, with
// wrap-around. Purely combinational.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_last_grant,
  output logic                       o_grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_idx
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;
  logic          w_found;
  logic [IW-1:0] w_idx;

  // One extra bit on the sum lets the wrap be done with a single subtract
  always_comb begin
    w_sum   = {(IW+1){1'b0}};
    w_cand  = {IW{1'b0}};
    w_found = 1'b0;
    w_idx   = {IW{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_sum  = {1'b0, i_last_grant} + (IW+1)'(i);
      w_sum  = (w_sum >= (IW+1)'(NUM_REQ)) ? (w_sum - (IW+1)'(NUM_REQ)) : w_sum;
      w_cand = w_sum[IW-1:0];
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign o_grant_valid = w_found;
  assign o_grant_idx   = w_idx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte producers: round-robin grant,
// one TXstart per byte, and TX_busy tracking so a start never lands on a busy transmitter.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           TXstart,
  output logic [UART_DATA_W-1:0]         TX_data_in,
  input  logic                           TX_busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           tx_active,
  output logic                           timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0]      CNT_LAST       = CW'(BUSY_TIMEOUT);
  localparam logic [CW-1:0]      CNT_PRE        = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0]      CNT_ONE        = CW'(1);
  localparam logic [NUM_REQ-1:0] READY_LSB      = NUM_REQ'(1);
  localparam logic [IW-1:0]      LAST_GRANT_RST = IW'(NUM_REQ - 1);

  uart_arb_state_e        r_state;
  logic [IW-1:0]          r_last_grant;
  logic [IW-1:0]          r_grant_id;
  logic [CW-1:0]          r_cnt;
  logic [NUM_REQ-1:0]     r_req_ready;
  logic                   r_txstart;
  logic [UART_DATA_W-1:0] r_data;
  logic                   r_tx_active;
  logic                   r_timeout_err;

  logic                   w_grant_valid;
  logic [IW-1:0]          w_grant_idx;
  logic [UART_DATA_W-1:0] w_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data[g*UART_DATA_W +: UART_DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req         (req_valid),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  // Grant FSM with registered outputs; timeout_err is raised one count early so the
  // pulse coincides with the counter reaching BUSY_TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ARB_IDLE;
      r_last_grant  <= LAST_GRANT_RST;
      r_grant_id    <= {IW{1'b0}};
      r_cnt         <= {CW{1'b0}};
      r_req_ready   <= {NUM_REQ{1'b0}};
      r_txstart     <= 1'b0;
      r_data        <= {UART_DATA_W{1'b0}};
      r_tx_active   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_timeout_err <= 1'b0;
          if (w_grant_valid && !TX_busy) begin
            r_data       <= w_bytes[w_grant_idx];
            r_grant_id   <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_req_ready  <= READY_LSB << w_grant_idx;
            r_txstart    <= 1'b1;
            r_tx_active  <= 1'b1;
            r_state      <= ARB_START;
          end else begin
            r_req_ready <= {NUM_REQ{1'b0}};
            r_txstart   <= 1'b0;
            r_tx_active <= 1'b0;
          end
        end
        ARB_START: begin
          r_req_ready <= {NUM_REQ{1'b0}};
          r_txstart   <= 1'b0;
          r_cnt       <= {CW{1'b0}};
          r_state     <= ARB_WAIT_BUSY;
        end
        ARB_WAIT_BUSY: begin
          if (r_cnt == CNT_LAST) begin
            r_timeout_err <= 1'b0;
            r_tx_active   <= 1'b0;
            r_state       <= ARB_IDLE;
          end else if (TX_busy) begin
            r_timeout_err <= 1'b0;
            r_state       <= ARB_WAIT_DONE;
          end else begin
            r_cnt         <= r_cnt + CNT_ONE;
            r_timeout_err <= (r_cnt == CNT_PRE);
          end
        end
        ARB_WAIT_DONE: begin
          if (!TX_busy) begin
            r_tx_active <= 1'b0;
            r_state     <= ARB_IDLE;
          end else begin
            r_state <= ARB_WAIT_DONE;
          end
        end
        default: begin
          r_req_ready   <= {NUM_REQ{1'b0}};
          r_txstart     <= 1'b0;
          r_tx_active   <= 1'b0;
          r_timeout_err <= 1'b0;
          r_state       <= ARB_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign TXstart     = r_txstart;
  assign TX_data_in  = r_data;
  assign grant_id    = r_grant_id;
  assign tx_active   = r_tx_active;
  assign timeout_err = r_timeout_err;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between `NUM_REQ` byte-producing requesters. A round-robin scheduler selects one pending requester, drives `TX_data_in` and a one-cycle `TXstart` pulse, and then tracks `TX_busy` to detect the end of the frame before granting again. It sits between the requester clients and the transmitter's `TXstart`/`TX_data_in`/`TX_busy` ports. It guarantees that `TXstart` is never issued while `TX_busy` is high.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `BUSY_TIMEOUT`, 16: maximum number of cycles the block waits for `TX_busy` to rise after `TXstart`.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i has a byte pending. It stays high, with data stable, until `req_ready[i]` is seen.
- `req_data`  in  NUM_REQ*8  byte of requester i, at bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot, single-cycle acceptance pulse.
- `TXstart`  out  1  single-cycle start pulse to the transmitter.
- `TX_data_in`  out  8  byte to transmit. Held stable from `TXstart` until the block returns to IDLE.
- `TX_busy`  in  1  transmitter busy flag.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- `tx_active`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  single-cycle pulse when `TX_busy` fails to rise in time.

## Operation
- FSM states are IDLE, START, WAIT_BUSY and WAIT_DONE.
- **IDLE**
  - The block grants only when some `req_valid` is high and `TX_busy`=0.
  - Winner: the first valid index searching upward, with wrap-around, from `last_grant+1`.
  - On grant:
    - latch `req_data[winner]` into `TX_data_in`;
    - set `grant_id` and `last_grant` to the winner;
    - go to START.
  - If `TX_busy`=1 in IDLE, the block holds and grants nothing.
- **START**
  - `TXstart`=1 and `req_ready[grant_id]`=1 for exactly this one cycle.
  - Clear the timeout counter and go to WAIT_BUSY unconditionally.
- **WAIT_BUSY**
  - If `TX_busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter equals `BUSY_TIMEOUT`, pulse `timeout_err` for one cycle and go to IDLE.
  - On a timeout the byte is dropped: it has already been accepted and is not retried.
- **WAIT_DONE**
  - When `TX_busy`=0, go to IDLE. Otherwise stay.
- Round-robin pointer:
  - `last_grant` updates only on a grant.
  - With all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0.
- Counter width is $clog2(BUSY_TIMEOUT+1). It saturates and never wraps.
- A requester that drops `req_valid` before its grant is simply skipped. No error is flagged.

## Timing
- Reset values:
  - state = IDLE;
  - `TXstart`=0, `req_ready`=0, `TX_data_in`=8'h00;
  - `grant_id`=0, `tx_active`=0, `timeout_err`=0;
  - `last_grant`=NUM_REQ-1, so the first grant after reset goes to index 0 when it is valid.
- All outputs are registered.
- Latency: if the grant condition holds in cycle N, `TXstart`, `req_ready[i]` and the new `TX_data_in` are all high/valid in cycle N+1.
- Minimum spacing between two `TXstart` pulses: START + WAIT_BUSY(≥1) + WAIT_DONE(≥1) + IDLE = 4 cycles.
- `TX_busy` rising in the same cycle as START is ignored. It is evaluated from WAIT_BUSY onward.
- Timeout: with `TX_busy` stuck low, `timeout_err` is high in cycle N+1+BUSY_TIMEOUT+1 relative to the grant decision in cycle N. IDLE follows in the next cycle.
- `rst` takes priority over every transition. Asserting it mid-frame forces the reset values on the next edge; the transmitter's in-flight frame is not tracked.

## Structure
- Shared package `uart_pkg`:
  - `uart_arb_state_e` enum;
  - `UART_DATA_W`=8;
  - default `BUSY_TIMEOUT` constant.
- Sub-module `rr_arbiter`:
  - parameterised by `NUM_REQ`;
  - inputs: request vector, `last_grant`;
  - outputs: `grant_valid`, `grant_idx`;
  - purely combinational rotating-priority search.
- Top level holds the FSM, the data/grant registers and the timeout counter.

## Test plan
- **Single request.** Reset, then `req_valid`=4'b0100 with byte 8'hA5. Bench models `TX_busy` high 2 cycles after `TXstart` for 10 cycles. Expect `req_ready`=4'b0100 and `TXstart` together one cycle after valid, `TX_data_in`=8'hA5 stable throughout, `grant_id`=2, return to IDLE.
- **Fairness.** All four requesters valid continuously with bytes 8'h10..8'h13. Expect grant order 0,1,2,3,0 and `TX_data_in` sequence 10,11,12,13,10. Never two `TXstart` pulses within 4 cycles.
- **Busy blocking.** Hold `TX_busy`=1 externally while `req_valid`=4'b0001. Expect no `TXstart` until `TX_busy` falls, then a grant one cycle later.
- **Timeout.** `TX_busy` tied low, one request. Expect `timeout_err` pulse exactly once, `BUSY_TIMEOUT`+2 cycles after the decision. The block then returns to IDLE and serves the next request.
- **Reset mid-operation.** Assert `rst` during WAIT_DONE. Expect all outputs at reset values on the next edge. The next grant goes to index 0 when it is valid.
